// File: rtl/uart_frame_pkg.sv
// Shared definitions for the "&&payload&&" frame receiver: FSM encoding,
// delimiter byte, error codes and the inter-byte timeout sizing helper.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SOF1 = 2'd1,
        S_BODY = 2'd2,
        S_EOF1 = 2'd3
    } frame_state_e;

    localparam logic [7:0] FrameDelim = 8'h26;  // '&'

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrBadTerm = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    // Gap limit in clock cycles: cycles per bit * 10 bits per char * chars.
    function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                   input int unsigned baud_rate,
                                                   input int unsigned n_bytes);
        return (clk_freq / baud_rate) * 10 * n_bytes;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte gap timer. Counts enabled cycles since the last clear and
// raises a combinational expire in the cycle that would be the LIMIT-th one,
// unless a clear arrives in that same cycle.
module uart_frame_timer #(
    parameter int unsigned LIMIT = 17360
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CntW-1:0] Last = CntW'(LIMIT - 1);

    logic [CntW-1:0] count_q;

    // Gap counter; held at zero while idle or on every received byte.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear || !enable) begin
            count_q <= '0;
        end else if (count_q != Last) begin
            count_q <= count_q + 1'b1;
        end
    end

    // A byte in the limit cycle wins over the timeout.
    always_comb begin
        expire = enable && !clear && (count_q == Last);
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver for "&&payload&&" byte streams coming from a UART.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned MAX_LEN       = 128,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_vld,
    output logic [8*MAX_LEN-1:0] frame_data,
    output logic [7:0]           frame_len,
    output logic                 frame_done,
    output logic                 frame_busy,
    output logic                 frame_err,
    output logic [1:0]           err_code
);

    localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

    frame_state_e         state_q, state_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [8*MAX_LEN-1:0] data_q, data_d;
    logic [7:0]           len_q, len_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic                 busy_q;

`ifdef UART_FRAME_TIMEOUT_EN
    logic timer_expire;

    uart_frame_timer #(
        .LIMIT(timeout_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES))
    ) u_timer (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .clear  (rx_vld),
        .enable (state_q != S_IDLE),
        .expire (timer_expire)
    );
`endif

    // Next-state decode: delimiter framing, payload capture and error pulses.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        if (rx_vld) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == FrameDelim) state_d = S_SOF1;
                end
                S_SOF1: begin
                    if (rx_data == FrameDelim) begin
                        state_d = S_BODY;
                        buf_d   = '0;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BODY: begin
                    if (rx_data == FrameDelim) begin
                        state_d = S_EOF1;
                    end else if (cnt_q < MaxLenB) begin
                        buf_d[32'(cnt_q)*8 +: 8] = rx_data;
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ErrOverflow;
                        state_d = S_IDLE;
                    end
                end
                S_EOF1: begin
                    state_d = S_IDLE;
                    if (rx_data == FrameDelim) begin
                        data_d = buf_q;
                        len_d  = cnt_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ErrBadTerm;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef UART_FRAME_TIMEOUT_EN
        else if (timer_expire) begin
            err_d   = 1'b1;
            code_d  = ErrTimeout;
            state_d = S_IDLE;
        end
`endif
    end

    // State and output registers; reset drops any partial frame silently.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= 8'd0;
            data_q  <= '0;
            len_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Drive ports straight from registers.
    always_comb begin
        frame_data = data_q;
        frame_len  = len_q;
        frame_done = done_q;
        frame_err  = err_q;
        err_code   = code_q;
        frame_busy = busy_q;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx (default parameters). The stimulus
// process pushes the expected frame_done/frame_err event; a negedge monitor
// pops and compares whenever the DUT pulses. Timeout cases depend on
// UART_FRAME_TIMEOUT_EN being defined for both bench and RTL.
module tb_uart_frame_rx;

    localparam int unsigned MaxLen = 128;
    localparam int unsigned Limit  = 17360;

    typedef struct {
        logic           is_err;
        logic [1:0]     code;
        logic [7:0]     len;
        logic [1023:0]  data;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_vld  = 1'b0;
    logic [1023:0] frame_data;
    logic [7:0]    frame_len;
    logic          frame_done;
    logic          frame_busy;
    logic          frame_err;
    logic [1:0]    err_code;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [7:0]    good_len  = 8'd0;
    logic [1023:0] good_data = '0;

    uart_frame_rx dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx_data   (rx_data),
        .rx_vld    (rx_vld),
        .frame_data(frame_data),
        .frame_len (frame_len),
        .frame_done(frame_done),
        .frame_busy(frame_busy),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_data(input string name, input logic [1023:0] act,
                                     input logic [1023:0] exp);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s[%0d]", name, k), act[k*256 +: 256], exp[k*256 +: 256]);
        end
    endfunction

    function automatic void expect_done(input logic [7:0] len, input logic [1023:0] data);
        exp_t e;
        e.is_err  = 1'b0;
        e.code    = 2'd0;
        e.len     = len;
        e.data    = data;
        good_len  = len;
        good_data = data;
        sb_q.push_back(e);
    endfunction

    function automatic void expect_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.len    = good_len;
        e.data   = good_data;
        sb_q.push_back(e);
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge sys_clk);
        rx_vld  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic check_all_zero(input string tag);
        chk_data({tag, "_data"}, frame_data, '0);
        chk({tag, "_len"}, 256'(frame_len), 256'd0);
        chk({tag, "_done"}, 256'(frame_done), 256'd0);
        chk({tag, "_busy"}, 256'(frame_busy), 256'd0);
        chk({tag, "_err"}, 256'(frame_err), 256'd0);
        chk({tag, "_code"}, 256'(err_code), 256'd0);
    endtask

    // Monitor: pop the oldest expectation on every output pulse.
    always @(negedge sys_clk) begin
        if (frame_done || frame_err) begin
            chk("done_err_exclusive", 256'(frame_done & frame_err), 256'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none",
                         frame_done, frame_err);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind_err", 256'(frame_err), 256'(mon_e.is_err));
                chk("pulse_kind_done", 256'(frame_done), 256'(!mon_e.is_err));
                chk("frame_len", 256'(frame_len), 256'(mon_e.len));
                chk_data("frame_data", frame_data, mon_e.data);
                if (mon_e.is_err) chk("err_code", 256'(err_code), 256'(mon_e.code));
            end
        end
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check_all_zero("reset");

        // Basic three-byte frame.
        expect_done(8'd3, 1024'h314241);
        send_str("&&AB1&&");

        // Empty frame, then noise that must not pulse.
        expect_done(8'd0, '0);
        send_str("&&&&");
        send_str("x&");
        chk("busy_after_sof1", 256'(frame_busy), 256'd1);
        send_str("y");
        chk("busy_after_noise", 256'(frame_busy), 256'd0);

        // Good frame, then a bad terminator keeps it.
        expect_done(8'd1, 1024'h51);
        send_str("&&Q&&");
        expect_err(2'd1);
        send_str("&&AB&C");
        chk("busy_after_bad_term", 256'(frame_busy), 256'd0);

        // Exactly MAX_LEN bytes is accepted.
        expect_done(8'd128, {128{8'h41}});
        send_str("&&");
        for (int i = 0; i < MaxLen; i++) send(8'h41);
        send_str("&&");

        // One byte more overflows on the final byte only.
        send_str("&&");
        for (int i = 0; i < MaxLen; i++) send(8'h41);
        chk("no_err_before_overflow", 256'(frame_err), 256'd0);
        expect_err(2'd2);
        send(8'h41);
        chk("busy_after_overflow", 256'(frame_busy), 256'd0);

        // Reset mid-frame discards everything with no pulse.
        send_str("&&AB");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        good_len  = 8'd0;
        good_data = '0;
        check_all_zero("midreset");
        expect_done(8'd1, 1024'h5A);
        send_str("&&Z&&");

`ifdef UART_FRAME_TIMEOUT_EN
        // Idle after 'B': error lands exactly Limit cycles after the byte.
        send_str("&&AB");
        repeat (Limit - 1) @(negedge sys_clk);
        chk("no_timeout_early", 256'(frame_err), 256'd0);
        expect_err(2'd3);
        @(negedge sys_clk);
        chk("timeout_pulse", 256'(frame_err), 256'd1);
        chk("timeout_code", 256'(err_code), 256'd3);

        // A byte in the limit cycle is taken instead of timing out.
        send_str("&&AB");
        repeat (Limit - 2) @(negedge sys_clk);
        send(8'h43);
        chk("limit_byte_no_err", 256'(frame_err), 256'd0);
        chk("limit_byte_busy", 256'(frame_busy), 256'd1);
        expect_done(8'd3, 1024'h434241);
        send_str("&&");
`else
        // Without the timer an incomplete frame waits indefinitely.
        send_str("&&AB");
        repeat (Limit + 2000) @(negedge sys_clk);
        chk("no_timeout_busy", 256'(frame_busy), 256'd1);
        expect_done(8'd2, 1024'h4241);
        send_str("&&");
`endif

        repeat (4) @(negedge sys_clk);
        chk("scoreboard_drained", 256'(sb_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
